mbus_rd_arbiter: RTL and testbench

MBUS_RD_ARBITER -- requirements
Module: mbus_rd_arbiter

---
 rtl/mbus_pkg.sv | 28 ++
 rtl/mbus_tag_fifo.sv | 68 ++++++
 rtl/mbus_rd_arbiter.sv | 100 ++++++++++
 tb/tb_mbus_rd_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbus_pkg.sv
// Shared constants, tag type and arbitration helper for the MBUS read arbiter.
package mbus_pkg;

    localparam int REQ_SCALAR = 0;
    localparam int REQ_VECTOR = 1;
    localparam int NUM_REQ    = 2;

    typedef logic tag_t;

    // Pick a requester: hold keeps the previous owner, a tie goes to the
    // requester that was not granted last.
    function automatic tag_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                     input tag_t               last,
                                     input logic               hold);
        tag_t pick;
        if (hold) begin
            pick = last;
        end else begin
            case (valid)
                2'b01:   pick = 1'b0;
                2'b10:   pick = 1'b1;
                default: pick = ~last;
            endcase
        end
        return pick;
    endfunction

endpackage

// File: rtl/mbus_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding read, in issue order.
module mbus_tag_fifo
    import mbus_pkg::*;
#(
    parameter int DEPTH_BITS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    tag_t                  mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // The count never exceeds DEPTH, so its top bit alone marks full.
    assign full  = count_q[DEPTH_BITS];
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (DEPTH_BITS + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (DEPTH_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_tag;
        end
    end

endmodule

// File: rtl/mbus_rd_arbiter.sv
// Two-requester (scalar/vector) read arbiter onto one MBUS read port.
// Define MBUS_ARB_LOCK_EN to let req_lock hold the grant for bursts.
module mbus_rd_arbiter
    import mbus_pkg::*;
#(
    parameter int MBUS_ADDR_WIDTH = 32,
    parameter int MBUS_DATA_WIDTH = 32,
    parameter int OUTS_BITS       = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [2*MBUS_ADDR_WIDTH-1:0]   req_ar_addr,
    input  logic [NUM_REQ-1:0]             req_ar_valid,
    output logic [NUM_REQ-1:0]             req_ar_ready,
    input  logic [NUM_REQ-1:0]             req_lock,
    output logic [MBUS_DATA_WIDTH-1:0]     req_r_data,
    output logic [NUM_REQ-1:0]             req_r_valid,
    input  logic [NUM_REQ-1:0]             req_r_ready,
    output logic [MBUS_ADDR_WIDTH-1:0]     mbus_ar_addr,
    output logic                           mbus_ar_valid,
    input  logic                           mbus_ar_ready,
    input  logic [MBUS_DATA_WIDTH-1:0]     mbus_r_data,
    input  logic                           mbus_r_valid,
    output logic                           mbus_r_ready,
    output logic                           busy,
    output logic                           err_spurious
);

    tag_t grant;
    tag_t last_grant_q, last_grant_d;
    logic err_q, err_d;
    logic hold;
    logic ar_hs, r_pop;
    logic tag_full, tag_empty;
    tag_t tag_head;

`ifdef MBUS_ARB_LOCK_EN
    assign hold = req_lock[last_grant_q] & req_ar_valid[last_grant_q];
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign hold        = 1'b0;
`endif

    always_comb begin
        grant         = rr_pick(req_ar_valid, last_grant_q, hold);
        mbus_ar_addr  = grant ? req_ar_addr[2*MBUS_ADDR_WIDTH-1:MBUS_ADDR_WIDTH]
                              : req_ar_addr[MBUS_ADDR_WIDTH-1:0];
        mbus_ar_valid = req_ar_valid[grant] & ~tag_full;
        req_ar_ready  = '0;
        req_ar_ready[grant] = mbus_ar_ready & ~tag_full;
    end

    assign ar_hs = mbus_ar_valid & mbus_ar_ready;

    // With no outstanding read the response is swallowed rather than stalled.
    always_comb begin
        req_r_valid  = '0;
        mbus_r_ready = 1'b1;
        if (!tag_empty) begin
            req_r_valid[tag_head] = mbus_r_valid;
            mbus_r_ready          = req_r_ready[tag_head];
        end
    end

    assign r_pop      = mbus_r_valid & mbus_r_ready & ~tag_empty;
    assign req_r_data = mbus_r_data;
    assign busy       = ~tag_empty;

    always_comb begin
        last_grant_d = ar_hs ? grant : last_grant_q;
        err_d        = err_q | (mbus_r_valid & tag_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign err_spurious = err_q;

    mbus_tag_fifo #(
        .DEPTH_BITS (OUTS_BITS)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ar_hs),
        .push_tag (grant),
        .pop      (r_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

endmodule

// File: tb/tb_mbus_rd_arbiter.sv
// Scoreboard bench for mbus_rd_arbiter: random and directed traffic against a queue-based model.
module tb_mbus_rd_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int OB    = 3;
    localparam int DEPTH = 1 << OB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   ar_addr [2];
    logic [2*AW-1:0] req_ar_addr;
    logic [1:0]      ar_valid, req_ar_ready, req_lock;
    logic [DW-1:0]   req_r_data;
    logic [1:0]      req_r_valid, r_ready;
    logic [AW-1:0]   mbus_ar_addr;
    logic            mbus_ar_valid, mbus_ar_ready;
    logic [DW-1:0]   mbus_r_data;
    logic            mbus_r_valid, mbus_r_ready;
    logic            busy, err_spurious;

    assign req_ar_addr = {ar_addr[1], ar_addr[0]};

    always #5 clk = ~clk;

    mbus_rd_arbiter #(
        .MBUS_ADDR_WIDTH (AW),
        .MBUS_DATA_WIDTH (DW),
        .OUTS_BITS       (OB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_ar_addr   (req_ar_addr),
        .req_ar_valid  (ar_valid),
        .req_ar_ready  (req_ar_ready),
        .req_lock      (req_lock),
        .req_r_data    (req_r_data),
        .req_r_valid   (req_r_valid),
        .req_r_ready   (r_ready),
        .mbus_ar_addr  (mbus_ar_addr),
        .mbus_ar_valid (mbus_ar_valid),
        .mbus_ar_ready (mbus_ar_ready),
        .mbus_r_data   (mbus_r_data),
        .mbus_r_valid  (mbus_r_valid),
        .mbus_r_ready  (mbus_r_ready),
        .busy          (busy),
        .err_spurious  (err_spurious)
    );

    typedef struct {
        int            req;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t tag_q [$];
    int   checks = 0;
    int   errors = 0;
    int   last_exp;
    bit   err_exp;
    bit   push_pend, pop_pend, spur_pend;
    txn_t push_txn;
    bit [1:0] hs_q;
    int   grant_log [$];
    bit   log_en = 1'b0;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hA;
        if (a == 32'h104) return 32'hB;
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester the rules say should win this cycle, -1 when nobody asks.
    function automatic int pick(input logic [1:0] v, input logic [1:0] lk, input int last);
        if (v == 2'b11) begin
`ifdef MBUS_ARB_LOCK_EN
            if (lk[last]) return last;
`endif
            return 1 - last;
        end
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    // Address-side scoreboard producer: checks AR outputs and queues the expected response.
    always @(negedge clk) begin
        if (rst_n) begin
            int         w;
            bit         full;
            logic [1:0] rdy_e;
            w    = pick(ar_valid, req_lock, last_exp);
            full = (tag_q.size() == DEPTH);
            check("busy", busy, tag_q.size() != 0);
            check("err_spurious", err_spurious, err_exp);
            if (w >= 0) begin
                rdy_e = '0;
                if (!full && mbus_ar_ready) rdy_e[w] = 1'b1;
                check("ar_ready", req_ar_ready, rdy_e);
                check("mbus_ar_valid", mbus_ar_valid, !full);
                if (!full) check("mbus_ar_addr", mbus_ar_addr, ar_addr[w]);
                if (!full && mbus_ar_ready) begin
                    push_pend = 1'b1;
                    push_txn  = '{w, ar_addr[w], mem_data(ar_addr[w])};
                    if (log_en) grant_log.push_back(req_ar_ready[1] ? 1 : (req_ar_ready[0] ? 0 : -1));
                end
            end else begin
                check("mbus_ar_valid_idle", mbus_ar_valid, 1'b0);
            end
        end
    end

    // Response-side monitor: pops the expected owner/data whenever the DUT presents read data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tag_q.size() > 0) begin
                int         h;
                logic [1:0] rv_e;
                h    = tag_q[0].req;
                rv_e = '0;
                if (mbus_r_valid) rv_e[h] = 1'b1;
                check("r_valid_route", req_r_valid, rv_e);
                check("mbus_r_ready", mbus_r_ready, r_ready[h]);
                if (mbus_r_valid && r_ready[h]) begin
                    check("r_data", req_r_data, tag_q[0].data);
                    pop_pend = 1'b1;
                end
            end else if (mbus_r_valid) begin
                check("spur_r_valid", req_r_valid, 2'b00);
                check("spur_r_ready", mbus_r_ready, 1'b1);
                spur_pend = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q.delete();
            last_exp  = 1;
            err_exp   = 1'b0;
            push_pend = 1'b0;
            pop_pend  = 1'b0;
            spur_pend = 1'b0;
            hs_q      = '0;
        end else begin
            hs_q = '0;
            if (pop_pend) void'(tag_q.pop_front());
            if (push_pend) begin
                tag_q.push_back(push_txn);
                last_exp = push_txn.req;
                hs_q[push_txn.req] = 1'b1;
            end
            if (spur_pend) err_exp = 1'b1;
            push_pend = 1'b0;
            pop_pend  = 1'b0;
            spur_pend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int i);
        for (int c = 0; c < 50; c++) begin
            tick();
            if (hs_q[i]) return;
        end
        check("timeout_hs", 0, 1);
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && tag_q.size() > 0; c++) begin
            mbus_r_valid = 1'b1;
            mbus_r_data  = tag_q[0].data;
            r_ready      = 2'b11;
            tick();
        end
        mbus_r_valid = 1'b0;
        if (tag_q.size() > 0) check("timeout_drain", tag_q.size(), 0);
    endtask

    task automatic rand_cycle();
        tick();
        for (int i = 0; i < 2; i++) begin
            if (hs_q[i] || !ar_valid[i]) begin
                ar_valid[i] = ($urandom_range(0, 99) < 60);
                ar_addr[i]  = $urandom & ~32'h3;
            end
            r_ready[i] = ($urandom_range(0, 99) < 75);
        end
        req_lock      = 2'($urandom_range(0, 3));
        mbus_ar_ready = ($urandom_range(0, 99) < 70);
        if (tag_q.size() > 0) begin
            mbus_r_valid = ($urandom_range(0, 99) < 50);
            mbus_r_data  = tag_q[0].data;
        end else begin
            mbus_r_valid = ($urandom_range(0, 99) == 0);
            mbus_r_data  = $urandom;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr [4];
        exp_rr = '{0, 1, 0, 1};
        rst_n = 1'b0; ar_valid = '0; req_lock = '0; r_ready = '0;
        ar_addr[0] = '0; ar_addr[1] = '0;
        mbus_ar_ready = 1'b0; mbus_r_valid = 1'b0; mbus_r_data = '0;
        tick(); tick();
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_spurious, 1'b0);
        check("rst_ar_valid", mbus_ar_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Round-robin with both requesters asking every cycle.
        ar_valid = 2'b11; ar_addr[0] = 32'h200; ar_addr[1] = 32'h300;
        mbus_ar_ready = 1'b1; r_ready = 2'b11; log_en = 1'b1;
        for (int c = 0; c < 20 && grant_log.size() < 4; c++) begin
            tick();
            for (int i = 0; i < 2; i++) if (hs_q[i]) ar_addr[i] += 4;
        end
        log_en = 1'b0; ar_valid = 2'b00;
        check("rr_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) check("rr_grant", grant_log[k], exp_rr[k]);
        drain();
        tick();
        check("rr_busy_done", busy, 1'b0);

        // Two scalar reads returning 0xA and 0xB.
        ar_valid = 2'b01; ar_addr[0] = 32'h100;
        wait_hs(0);
        ar_addr[0] = 32'h104;
        wait_hs(0);
        ar_valid = 2'b00;
        check("scalar_outstanding", tag_q.size(), 2);
        drain();
        tick();
        check("scalar_busy_done", busy, 1'b0);

`ifdef MBUS_ARB_LOCK_EN
        begin
            int exp_lk [4];
            exp_lk = '{1, 1, 1, 0};
            grant_log.delete();
            ar_valid = 2'b10; req_lock = 2'b10; ar_addr[1] = 32'h4000; ar_addr[0] = 32'h5000;
            wait_hs(1);
            ar_addr[1] += 4; ar_valid = 2'b11; log_en = 1'b1;
            for (int c = 0; c < 40 && grant_log.size() < 3; c++) begin
                tick();
                if (hs_q[1]) ar_addr[1] += 4;
            end
            req_lock = 2'b00; ar_valid = 2'b01;
            for (int c = 0; c < 40 && grant_log.size() < 4; c++) tick();
            log_en = 1'b0; ar_valid = 2'b00;
            check("lock_count", grant_log.size(), 4);
            for (int k = 0; k < 4 && k < grant_log.size(); k++) check("lock_grant", grant_log[k], exp_lk[k]);
            drain();
            tick();
        end
`endif

        // Fill all tag slots, then show a pop frees exactly one slot a cycle later.
        ar_valid = 2'b01; mbus_ar_ready = 1'b1; mbus_r_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            ar_addr[0] = 32'h1000 + 32'(k * 4);
            wait_hs(0);
        end
        ar_addr[0] = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            #2 check("full_ar_ready", req_ar_ready, 2'b00);
            check("full_ar_valid", mbus_ar_valid, 1'b0);
            tick();
        end
        mbus_r_valid = 1'b1; mbus_r_data = tag_q[0].data; r_ready = 2'b11;
        #2 check("full_pop_cycle_ready", req_ar_ready, 2'b00);
        tick();
        mbus_r_valid = 1'b0;
        #2 check("after_pop_ready", req_ar_ready, 2'b01);
        tick();
        ar_valid = 2'b00;
        drain();
        tick();

        // Response with nothing outstanding, then reset clears the sticky flag.
        mbus_r_valid = 1'b1; mbus_r_data = 32'hDEAD;
        #2 check("idle_r_ready", mbus_r_ready, 1'b1);
        check("idle_r_valid", req_r_valid, 2'b00);
        tick();
        mbus_r_valid = 1'b0;
        #2 check("spur_set", err_spurious, 1'b1);
        rst_n = 1'b0;
        #2 check("spur_cleared", err_spurious, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic with a reset dropped in while reads are outstanding.
        for (int c = 0; c < 3000; c++) begin
            rand_cycle();
            if (c == 1500) begin
                rst_n = 1'b0;
                #2 check("midrst_busy", busy, 1'b0);
                tick();
                rst_n = 1'b1;
            end
        end
        ar_valid = 2'b00;
        drain();
        tick();
        check("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
